// File: rtl/reg_scoreboard_pkg.sv
// Shared processor constants for the register file and its pending-write scoreboard.
//   RegAddrW : architectural register-address width
//   NumRegs  : number of architectural registers
//   XzrIdx   : index of the hardwired-zero register (never written, never tracked)
//   XLEN     : register width
//   RfReadPorts / RfWritePorts : register-file port counts
package reg_scoreboard_pkg;

  localparam int unsigned RegAddrW     = 5;
  localparam int unsigned NumRegs      = 2 ** RegAddrW;
  localparam int unsigned XzrIdx       = 31;
  localparam int unsigned XLEN         = 64;
  localparam int unsigned RfReadPorts  = 2;
  localparam int unsigned RfWritePorts = 1;

  // Registered error pulses produced by the scoreboard.
  typedef struct packed {
    logic waw;
    logic clr;
  } sb_err_t;

endpackage

// File: rtl/decoder_n.sv
// Parametrised ADDR_W-to-2**ADDR_W one-hot decoder with enable.
//   en_i     : when low the output is all zeros
//   addr_i   : index to decode
//   onehot_o : one-hot vector, bit addr_i set when en_i is high
module decoder_n #(
  parameter int unsigned ADDR_W = 5,
  localparam int unsigned NUM_OUT = 2 ** ADDR_W
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NUM_OUT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      onehot_o[i] = en_i && (addr_i == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the architectural register file.
// Issue marks a destination register pending; writeback retires it. Source operands are
// checked against the registered pending vector to flag read-after-write hazards.
//   clk, reset             : rising-edge clock, asynchronous active-high reset
//   set_en, set_addr       : issue-stage destination becomes pending
//   clr_en, clr_addr       : writeback-stage pending write retires
//   rd_addr_a, rd_addr_b   : source operands queried
//   hazard_a, hazard_b     : combinational, queried source has a pending write
//   busy                   : registered pending-write vector
//   busy_count             : registered number of pending registers
//   waw_err                : one-cycle pulse, set to an already-pending register
//   clr_err                : one-cycle pulse, clear of a non-pending register
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W   = RegAddrW,
  parameter int unsigned ZERO_REG = XzrIdx,
  parameter int unsigned CNT_W    = ADDR_W + 1,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    busy_count,
  output logic                waw_err,
  output logic                clr_err
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0] set_dec, clr_dec;
  logic [NUM_REGS-1:0] set_hit, clr_hit;
  logic [NUM_REGS-1:0] track_mask;
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic [CNT_W-1:0]    count_d, count_q;
  logic                cnt_inc, cnt_dec;
  sb_err_t             err_d, err_q;

  decoder_n #(
    .ADDR_W (ADDR_W)
  ) u_set_dec (
    .en_i     (set_en),
    .addr_i   (set_addr),
    .onehot_o (set_dec)
  );

  decoder_n #(
    .ADDR_W (ADDR_W)
  ) u_clr_dec (
    .en_i     (clr_en),
    .addr_i   (clr_addr),
    .onehot_o (clr_dec)
  );

  // The zero register is dropped here so no later term can touch or report on it.
  always_comb begin
    track_mask           = '1;
    track_mask[ZERO_REG] = 1'b0;
    set_hit              = set_dec & track_mask;
    clr_hit              = clr_dec & track_mask;
  end

  always_comb begin
    // Set wins over a same-cycle clear of the same register.
    busy_d  = set_hit | (busy_q & ~clr_hit);

    // At most one bit of each hit vector is set, so each term is a 0/1 step.
    cnt_inc = |(set_hit & ~busy_q);
    cnt_dec = |(clr_hit & busy_q & ~set_hit);
    count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

    err_d.waw = |(set_hit & busy_q & ~clr_hit);
    err_d.clr = |(clr_hit & ~busy_q & ~set_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // No bypass of same-cycle set/clear: hazards come from registered state only.
  assign hazard_a   = busy_q[rd_addr_a] & (rd_addr_a != ZeroAddr);
  assign hazard_b   = busy_q[rd_addr_b] & (rd_addr_b != ZeroAddr);
  assign busy       = busy_q;
  assign busy_count = count_q;
  assign waw_err    = err_q.waw;
  assign clr_err    = err_q.clr;

`ifndef SYNTHESIS
  count_matches_busy: assert property (@(posedge clk) disable iff (reset)
    count_q == CNT_W'($countones(busy_q)));
  zero_reg_never_busy: assert property (@(posedge clk) disable iff (reset)
    !busy_q[ZERO_REG]);
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        reset;
  logic        set_en, clr_en;
  logic [4:0]  set_addr, clr_addr, rd_addr_a, rd_addr_b;
  logic        hazard_a, hazard_b;
  logic [31:0] busy;
  logic [5:0]  busy_count;
  logic        waw_err, clr_err;

  typedef struct {
    logic [31:0] busy;
    logic [5:0]  cnt;
    logic        waw;
    logic        cerr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_busy;
  int          checks = 0;
  int          errors = 0;

  reg_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .set_en     (set_en),
    .set_addr   (set_addr),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .hazard_a   (hazard_a),
    .hazard_b   (hazard_b),
    .busy       (busy),
    .busy_count (busy_count),
    .waw_err    (waw_err),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cnt"}, 64'(busy_count), 64'd0);
    check({tag, "_waw"}, 64'(waw_err), 64'd0);
    check({tag, "_clr"}, 64'(clr_err), 64'd0);
  endtask

  // One clock of stimulus: drive at the falling edge, check hazards against the current
  // model, push the expected post-edge state, then pop and compare after the rising edge.
  task automatic step(input string tag, input logic se, input logic [4:0] sa,
                      input logic ce, input logic [4:0] ca,
                      input logic [4:0] ra, input logic [4:0] rb);
    exp_t        e;
    logic [31:0] nb;
    logic        sh, ch;
    @(negedge clk);
    set_en = se; set_addr = sa; clr_en = ce; clr_addr = ca;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
    check({tag, "_haz_a"}, 64'(hazard_a), 64'(model_busy[ra] && (ra != 5'd31)));
    check({tag, "_haz_b"}, 64'(hazard_b), 64'(model_busy[rb] && (rb != 5'd31)));
    nb = model_busy;
    sh = se && (sa != 5'd31);
    ch = ce && (ca != 5'd31);
    e.waw = 1'b0;
    e.cerr = 1'b0;
    if (sh && ch && (sa == ca)) begin
      nb[sa] = 1'b1;
    end else begin
      if (ch) begin
        if (model_busy[ca]) nb[ca] = 1'b0;
        else e.cerr = 1'b1;
      end
      if (sh) begin
        if (model_busy[sa]) e.waw = 1'b1;
        else nb[sa] = 1'b1;
      end
    end
    e.busy = nb;
    e.cnt  = 6'($countones(nb));
    sb_q.push_back(e);
    model_busy = nb;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, "_busy"}, 64'(busy), 64'(e.busy));
    check({tag, "_cnt"}, 64'(busy_count), 64'(e.cnt));
    check({tag, "_waw"}, 64'(waw_err), 64'(e.waw));
    check({tag, "_clr"}, 64'(clr_err), 64'(e.cerr));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    set_en = 1'b0; set_addr = '0; clr_en = 1'b0; clr_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    model_busy = '0;

    // Reset state, and a set presented during reset is ignored.
    repeat (2) @(negedge clk);
    check_zero_state("reset");
    set_en = 1'b1; set_addr = 5'd5;
    @(posedge clk); #1;
    check_zero_state("set_in_reset");
    @(negedge clk);
    set_en = 1'b0;
    reset = 1'b0;

    // First edge after release processes the set; hazard only visible afterwards.
    step("set5", 1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd0);
    step("haz5", 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd5);

    // Same-cycle set and clear of the same busy register.
    step("setclr5", 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd6);

    // WAW pulse lasts exactly one cycle.
    step("waw5", 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0);
    idle("waw_gone");

    // Clear of a non-busy register pulses clr_err once.
    step("clr9", 1'b0, 5'd0, 1'b1, 5'd9, 5'd9, 5'd5);
    idle("clr_gone");

    // Zero register: ignored for set, clear and hazard.
    step("set31", 1'b1, 5'd31, 1'b0, 5'd0, 5'd5, 5'd31);
    step("clr31", 1'b0, 5'd0, 1'b1, 5'd31, 5'd31, 5'd31);

    // Set and clear of different registers in one cycle.
    step("set3", 1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd5);
    step("set7clr3", 1'b1, 5'd7, 1'b1, 5'd3, 5'd3, 5'd7);
    // Clear of non-busy alongside an unrelated set, and WAW alongside an unrelated clear.
    step("set8clr3", 1'b1, 5'd8, 1'b1, 5'd3, 5'd8, 5'd3);
    step("set7clr8", 1'b1, 5'd7, 1'b1, 5'd8, 5'd7, 5'd8);
    step("clr5", 1'b0, 5'd0, 1'b1, 5'd5, 5'd5, 5'd7);
    step("clr7", 1'b0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd0);

    // Fill every tracked register, then drain.
    for (int i = 0; i < 31; i++) step("fill", 1'b1, 5'(i), 1'b0, 5'd0, 5'(i), 5'd31);
    check("full_busy", 64'(busy), 64'h7FFF_FFFF);
    check("full_cnt", 64'(busy_count), 64'd31);
    for (int i = 0; i < 31; i++) step("drain", 1'b0, 5'd0, 1'b1, 5'(i), 5'(i), 5'(30 - i));
    check("empty_cnt", 64'(busy_count), 64'd0);

    // Asynchronous reset between edges clears state before the next edge.
    step("pre4", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0);
    step("pre5", 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0);
    step("prewaw", 1'b1, 5'd5, 1'b0, 5'd0, 5'd4, 5'd5);
    check("pre_busy", 64'(busy), 64'h30);
    @(negedge clk);
    set_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_zero_state("async_rst");
    model_busy = '0;
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 1'b1, 5'd2, 1'b0, 5'd0, 5'd2, 5'd4);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width; NUM_REGS = 2**ADDR_W.
REQ-002 Parameter ZERO_REG, default 31, index of the hardwired-zero register (XZR), never tracked.
REQ-003 Parameter CNT_W, default ADDR_W+1, width of busy_count.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 set_en  input  1  issue stage: destination register becomes pending.
REQ-007 set_addr  input  ADDR_W  destination register of issuing instruction.
REQ-008 clr_en  input  1  writeback stage: pending write retires.
REQ-009 clr_addr  input  ADDR_W  register being written back.
REQ-010 rd_addr_a, rd_addr_b  input  ADDR_W each  source operands queried.
REQ-011 hazard_a, hazard_b  output  1 each  queried source has a pending write.
REQ-012 busy  output  NUM_REGS  registered pending-write vector, bit i = register i.
REQ-013 busy_count  output  CNT_W  registered count of set bits in busy.
REQ-014 waw_err  output  1  registered one-cycle pulse: set issued to an already-pending register.
REQ-015 clr_err  output  1  registered one-cycle pulse: clear issued to a non-pending register.

Function
REQ-016 set_addr and clr_addr SHALL be decoded to one-hot NUM_REGS vectors gated by set_en / clr_en respectively.
REQ-017 Each rising clk: busy_next[i] = set_hit[i] | (busy[i] & ~clr_hit[i]).
REQ-018 Same-cycle set and clear of the same register: set wins; bit stays 1; busy_count unchanged; neither error pulses.
REQ-019 Set and clear of different registers in one cycle: both take effect; busy_count unchanged.
REQ-020 Set only to non-busy register: bit rises next cycle, busy_count +1; clear only of busy register: bit falls next cycle, busy_count -1.
REQ-021 Set to busy register without same-cycle clear to it: busy unchanged, busy_count unchanged, waw_err = 1 next cycle for exactly one cycle.
REQ-022 Clear of non-busy register (no same-cycle set to it): no state change, clr_err = 1 next cycle for one cycle.
REQ-023 Any set or clear addressing ZERO_REG SHALL be ignored: no state change, no error pulse; busy[ZERO_REG] is constant 0.
REQ-024 hazard_x SHALL be combinational: busy[rd_addr_x] & (rd_addr_x != ZERO_REG); it reflects registered state only (no same-cycle set/clear bypass).
REQ-025 busy_count SHALL always equal popcount(busy); it cannot wrap because max is NUM_REGS-1 < 2**CNT_W.
REQ-026 Latency: set/clear to busy/busy_count/err visibility = 1 cycle; query to hazard = 0 cycles.

Reset
REQ-027 While reset is high, busy = 0, busy_count = 0, waw_err = 0, clr_err = 0, immediately and independent of clk.
REQ-028 Reset asserted mid-operation discards all pending state; set/clear presented during reset have no effect.
REQ-029 First edge after reset deassertion SHALL process set/clear normally.

Structure
REQ-030 ADDR_W default, ZERO_REG default (XZR = 31) and NUM_REGS SHALL live in the shared processor package alongside the register-file constants.
REQ-031 One sub-module decoder_n (parametrised ADDR_W-to-2**ADDR_W one-hot decoder with enable), instantiated twice (set, clear); it supersedes the fixed-width decoders for new logic.
REQ-032 busy_count SHALL be a registered up/down counter updated from the same decode results, not a combinational popcount of busy.

Verification
REQ-033 Reset high, then set_en=1 set_addr=5 -> busy[5]=1, busy_count=1 one cycle after reset release edge; hazard_a=1 with rd_addr_a=5.
REQ-034 busy[5]=1; set_addr=5 and clr_addr=5 same cycle -> busy[5]=1, busy_count=1, waw_err=0, clr_err=0.
REQ-035 busy[5]=1; set_addr=5 alone -> waw_err high exactly one cycle, busy_count stays 1; clr_addr=9 alone (not busy) -> clr_err one-cycle pulse.
REQ-036 set_addr=31 and rd_addr_b=31 -> busy stays 0, hazard_b=0, no error pulses.
REQ-037 Set registers 0..30 on consecutive cycles -> busy_count=31, busy=0x7FFFFFFF; then clear all -> busy_count=0.
REQ-038 busy=0x0000_0030; assert reset between clock edges -> busy, busy_count and error outputs 0 before the next edge.
